// File: rtl/arbitro_registrador_if.sv
// Handshake and data bundle between two requesters and the shared
// register bank arbiter. The arbiter connects through the slave modport,
// the requester side (or a bench driving both requesters) through master.
interface arbitro_registrador_if #(
    parameter int WIDTH = 8
);
    // requester A transaction request
    logic             req_a;
    logic             we_a;
    logic [1:0]       addr_a;
    logic [WIDTH-1:0] wdata_a;

    // requester B transaction request
    logic             req_b;
    logic             we_b;
    logic [1:0]       addr_b;
    logic [WIDTH-1:0] wdata_b;

    // arbiter responses
    logic             gnt_a;
    logic             gnt_b;
    logic             ack_a;
    logic             ack_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             busy;

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        input  gnt_a, gnt_b, ack_a, ack_b, rdata_a, rdata_b, busy
    );

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        output gnt_a, gnt_b, ack_a, ack_b, rdata_a, rdata_b, busy
    );
endinterface

// File: rtl/arbitro_registrador.sv
// Two-requester round-robin arbiter guarding a bank of four WIDTH-bit
// registers. Each transaction walks IDLE -> SERV_x -> ACK_x -> IDLE, so a
// request sampled in IDLE is granted the next cycle and acknowledged the
// cycle after. The request fields are captured when leaving IDLE so the
// requester may change its inputs freely while the transaction runs.
module arbitro_registrador #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clrn,
    arbitro_registrador_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERV_A = 3'd1,
        SERV_B = 3'd2,
        ACK_A  = 3'd3,
        ACK_B  = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_s;

    // 1 = requester B was served last, so A wins the next tie
    logic             last_b_r;

    // transaction fields frozen on the IDLE -> SERV edge
    logic             we_r;
    logic [1:0]       addr_r;
    logic [WIDTH-1:0] wdata_r;

    logic [WIDTH-1:0] bank_r [4];

    logic [WIDTH-1:0] rdata_a_r;
    logic [WIDTH-1:0] rdata_b_r;
    logic             gnt_a_r;
    logic             gnt_b_r;
    logic             ack_a_r;
    logic             ack_b_r;
    logic             busy_r;

    // decoded strobes derived from the current state
    logic             serv_s;
    logic             bank_wr_s;
    logic             rd_a_s;
    logic             rd_b_s;
    logic             grant_a_s;
    logic             grant_b_s;

    // State register; reset abandons whatever transaction was in flight
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic with round-robin tie break in IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_a && bus.req_b) begin
                    if (last_b_r) begin
                        state_s = SERV_A;
                    end else begin
                        state_s = SERV_B;
                    end
                end else if (bus.req_a) begin
                    state_s = SERV_A;
                end else if (bus.req_b) begin
                    state_s = SERV_B;
                end else begin
                    state_s = IDLE;
                end
            end
            SERV_A:  state_s = ACK_A;
            SERV_B:  state_s = ACK_B;
            ACK_A:   state_s = IDLE;
            ACK_B:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Strobes for the bank access performed on the SERV -> ACK edge
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (state_r == IDLE) begin
            grant_a_s = (state_s == SERV_A);
            grant_b_s = (state_s == SERV_B);
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
        serv_s    = (state_r == SERV_A) || (state_r == SERV_B);
        bank_wr_s = serv_s && we_r;
        rd_a_s    = (state_r == SERV_A) && !we_r;
        rd_b_s    = (state_r == SERV_B) && !we_r;
    end

    // Last-served pointer, updated as each acknowledge completes
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            last_b_r <= 1'b1;
        end else if (state_r == ACK_A) begin
            last_b_r <= 1'b0;
        end else if (state_r == ACK_B) begin
            last_b_r <= 1'b1;
        end
    end

    // Capture the winner's command fields when the grant is issued
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            we_r    <= 1'b0;
            addr_r  <= 2'd0;
            wdata_r <= {WIDTH{1'b0}};
        end else if (grant_a_s) begin
            we_r    <= bus.we_a;
            addr_r  <= bus.addr_a;
            wdata_r <= bus.wdata_a;
        end else if (grant_b_s) begin
            we_r    <= bus.we_b;
            addr_r  <= bus.addr_b;
            wdata_r <= bus.wdata_b;
        end
    end

    // Register bank; written only by a granted write leaving SERV
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 4; i++) begin
                bank_r[i] <= {WIDTH{1'b0}};
            end
        end else if (bank_wr_s) begin
            bank_r[addr_r] <= wdata_r;
        end
    end

    // Per-requester read data, held until that requester reads again
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rdata_a_r <= {WIDTH{1'b0}};
            rdata_b_r <= {WIDTH{1'b0}};
        end else begin
            if (rd_a_s) begin
                rdata_a_r <= bank_r[addr_r];
            end
            if (rd_b_s) begin
                rdata_b_r <= bank_r[addr_r];
            end
        end
    end

    // Handshake outputs registered from the next state so they are glitch free
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            gnt_a_r <= 1'b0;
            gnt_b_r <= 1'b0;
            ack_a_r <= 1'b0;
            ack_b_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            gnt_a_r <= (state_s == SERV_A);
            gnt_b_r <= (state_s == SERV_B);
            ack_a_r <= (state_s == ACK_A);
            ack_b_r <= (state_s == ACK_B);
            busy_r  <= (state_s != IDLE);
        end
    end

    assign bus.gnt_a   = gnt_a_r;
    assign bus.gnt_b   = gnt_b_r;
    assign bus.ack_a   = ack_a_r;
    assign bus.ack_b   = ack_b_r;
    assign bus.busy    = busy_r;
    assign bus.rdata_a = rdata_a_r;
    assign bus.rdata_b = rdata_b_r;

endmodule

// File: tb/tb_arbitro_registrador.sv
// Directed bench for the two-requester register bank arbiter. Inputs are
// driven just after the falling edge and outputs sampled on falling edges.
module tb_arbitro_registrador;

    localparam int WIDTH = 8;

    logic clk;
    logic clrn;
    int   n_checks;
    int   n_errors;

    arbitro_registrador_if #(.WIDTH(WIDTH)) bus ();

    arbitro_registrador #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = 2'd0; bus.wdata_a = 8'h00;
        bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = 2'd0; bus.wdata_b = 8'h00;
    endtask

    task automatic apply_reset(input string tag);
        clrn = 1'b0;
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        repeat (2) tick();
        check_val({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check_val({tag, "_gnt"}, {30'd0, bus.gnt_a, bus.gnt_b}, 32'd0);
        check_val({tag, "_ack"}, {30'd0, bus.ack_a, bus.ack_b}, 32'd0);
        check_val({tag, "_rdata_a"}, {24'd0, bus.rdata_a}, 32'd0);
        check_val({tag, "_rdata_b"}, {24'd0, bus.rdata_b}, 32'd0);
        idle_inputs();
        clrn = 1'b1;
    endtask

    // single transaction by A: request now, check grant, ack and return to IDLE
    task automatic txn_a(input string tag, input logic we, input logic [1:0] addr,
                         input logic [7:0] wdata, input logic chk_rd, input logic [7:0] exp_rd);
        bus.req_a = 1'b1; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wdata;
        tick();
        check_val({tag, "_gnt_a"}, {30'd0, bus.gnt_a, bus.gnt_b}, 32'd2);
        bus.req_a = 1'b0;
        tick();
        check_val({tag, "_ack_a"}, {29'd0, bus.ack_a, bus.gnt_a, bus.busy}, 32'd5);
        if (chk_rd) check_val({tag, "_rdata_a"}, {24'd0, bus.rdata_a}, {24'd0, exp_rd});
        tick();
        check_val({tag, "_idle"}, {29'd0, bus.ack_a, bus.busy, bus.gnt_a}, 32'd0);
    endtask

    task automatic txn_b(input string tag, input logic [1:0] addr, input logic [7:0] exp_rd);
        bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = addr;
        tick();
        check_val({tag, "_gnt_b"}, {30'd0, bus.gnt_a, bus.gnt_b}, 32'd1);
        bus.req_b = 1'b0;
        tick();
        check_val({tag, "_ack_b"}, {31'd0, bus.ack_b}, 32'd1);
        check_val({tag, "_rdata_b"}, {24'd0, bus.rdata_b}, {24'd0, exp_rd});
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clrn = 1'b0;
        idle_inputs();

        // reset then A writes 0xA5 to addr 2 and reads it back
        apply_reset("rst0");
        txn_a("wr_a5", 1'b1, 2'd2, 8'hA5, 1'b0, 8'h00);
        check_val("wr_keeps_rdata_a", {24'd0, bus.rdata_a}, 32'h00);
        txn_a("rd_a5", 1'b0, 2'd2, 8'h00, 1'b1, 8'hA5);

        // simultaneous requests after reset: A first, B three cycles later
        apply_reset("rst1");
        bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 2'd0; bus.wdata_a = 8'h11;
        bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 2'd0; bus.wdata_b = 8'h22;
        tick();
        check_val("tie_c1_gnt", {30'd0, bus.gnt_a, bus.gnt_b}, 32'd2);
        bus.req_a = 1'b0;
        tick();
        check_val("tie_c2_ack", {30'd0, bus.ack_a, bus.ack_b}, 32'd2);
        tick();
        check_val("tie_c3_idle", {29'd0, bus.busy, bus.gnt_a, bus.gnt_b}, 32'd0);
        tick();
        check_val("tie_c4_gnt", {30'd0, bus.gnt_a, bus.gnt_b}, 32'd1);
        bus.req_b = 1'b0;
        tick();
        check_val("tie_c5_ack", {30'd0, bus.ack_a, bus.ack_b}, 32'd1);
        check_val("tie_wr_keeps_rdata_b", {24'd0, bus.rdata_b}, 32'h00);
        tick();
        txn_a("rd0_a", 1'b0, 2'd0, 8'h00, 1'b1, 8'h22);
        txn_b("rd0_b", 2'd0, 8'h22);
        check_val("rdata_a_held", {24'd0, bus.rdata_a}, 32'h22);

        // both hold requests for six transactions: A,B,A,B,A,B
        bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 2'd0;
        bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 2'd0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            check_val($sformatf("rr_c%0d_gnt", k), {30'd0, bus.gnt_a, bus.gnt_b},
                      (k % 6 == 1) ? 32'd2 : ((k % 6 == 4) ? 32'd1 : 32'd0));
        end
        idle_inputs();
        tick();

        // reset pulsed during SERV_B of a write: abandoned, bank cleared
        bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 2'd3; bus.wdata_b = 8'hFF;
        tick();
        check_val("abort_gnt_b", {31'd0, bus.gnt_b}, 32'd1);
        #2;
        clrn = 1'b0;
        #1;
        check_val("abort_busy_now", {29'd0, bus.busy, bus.gnt_a, bus.gnt_b}, 32'd0);
        bus.req_b = 1'b0;
        tick();
        clrn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val($sformatf("abort_no_ack_%0d", k), {29'd0, bus.ack_b, bus.ack_a, bus.busy}, 32'd0);
        end
        txn_a("abort_rd3", 1'b0, 2'd3, 8'h00, 1'b1, 8'h00);
        txn_a("abort_rd0", 1'b0, 2'd0, 8'h00, 1'b1, 8'h00);

        // input changes during SERV_A must not alter the captured write
        bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 2'd1; bus.wdata_a = 8'h0F;
        tick();
        check_val("cap_gnt_a", {31'd0, bus.gnt_a}, 32'd1);
        bus.wdata_a = 8'hF0; bus.addr_a = 2'd2; bus.we_a = 1'b0; bus.req_a = 1'b0;
        tick();
        check_val("cap_ack_a", {31'd0, bus.ack_a}, 32'd1);
        check_val("cap_no_read", {24'd0, bus.rdata_a}, 32'h00);
        tick();
        txn_b("cap_rd1", 2'd1, 8'h0F);
        txn_a("cap_rd2", 1'b0, 2'd2, 8'h00, 1'b1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
